// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache between fetch and the SDRAM read port.
// Cacheable fetches hit from on-chip line storage. A miss stalls fetch while one
// whole line is burst-read. A flush pulse invalidates every line. Fetches outside
// [CACHE_BASE, CACHE_LIMIT) bypass the cache: they never stall and never hit.
// Ports:
//   cpu_clk, reset_n           clock, asynchronous active-low reset
//   fetch_req, fetch_addr      fetch request and byte address (bits [1:0] ignored)
//   flush                      single-cycle pulse that invalidates all lines
//   stall                      fetch must hold its request (combinational)
//   instr_valid, instr_out     hit indication and instruction (NOP when no hit)
//   busy                       fill, re-read or flush in progress
//   mem_req, mem_addr          line read request and line-aligned word address
//   mem_rvalid, mem_rdata      read beats returned in word order
module icache_dm #(
  parameter int unsigned LINE_WORDS  = 16,
  parameter int unsigned NUM_LINES   = 128,
  parameter logic [31:0] CACHE_BASE  = 32'h0080_0000,
  parameter logic [31:0] CACHE_LIMIT = 32'h0100_0000
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        flush,
  output logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic        busy,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = 30 - OFF_W - IDX_W;
  localparam int unsigned RAM_AW = IDX_W + OFF_W;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {LOOKUP, FILL, REREAD, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [31:0]          la_q;
  logic                 lreq_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [OFF_W-1:0]     cnt_q;
  logic                 flush_pend_q;

  logic [31:0]          data_ram [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]     tag_ram  [NUM_LINES];
  logic [31:0]          data_q;
  logic [TAG_W-1:0]     tag_q;

  logic [TAG_W-1:0]     la_tag;
  logic [IDX_W-1:0]     la_idx;
  logic [RAM_AW-1:0]    ram_raddr;
  logic                 lookup_c, hit_c;
  logic                 start_fill, beat_we, fill_done, clear_valid;

  assign la_tag = la_q[31 -: TAG_W];
  assign la_idx = la_q[OFF_W+2 +: IDX_W];

  // While stalled the arrays keep reading the held lookup address.
  assign ram_raddr = stall ? la_q[2 +: RAM_AW] : fetch_addr[2 +: RAM_AW];

  assign lookup_c = lreq_q && (la_q >= CACHE_BASE) && (la_q < CACHE_LIMIT);
  assign hit_c    = lookup_c && valid_q[la_idx] && (tag_q == la_tag);

  // Line and tag storage: synchronous read, written only during a fill.
  always_ff @(posedge cpu_clk) begin
    if (beat_we) data_ram[{la_idx, cnt_q}] <= mem_rdata;
    if (fill_done) tag_ram[la_idx] <= la_tag;
    data_q <= data_ram[ram_raddr];
    tag_q  <= tag_ram[ram_raddr[OFF_W +: IDX_W]];
  end

  // State register.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) state_q <= LOOKUP;
    else          state_q <= state_d;
  end

  // Next state, fill/flush strobes and lookup outputs.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    busy        = 1'b0;
    instr_valid = 1'b0;
    instr_out   = NOP;
    start_fill  = 1'b0;
    beat_we     = 1'b0;
    fill_done   = 1'b0;
    clear_valid = 1'b0;
    unique case (state_q)
      LOOKUP: begin
        if (hit_c) begin
          instr_valid = 1'b1;
          instr_out   = data_q;
        end
        if (lookup_c && !hit_c) stall = 1'b1;
        // A flush wins over a miss; the held lookup is retried afterwards.
        if (flush) begin
          state_d = FLUSH;
        end else if (lookup_c && !hit_c) begin
          state_d    = FILL;
          start_fill = 1'b1;
        end
      end
      FILL: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (mem_rvalid) begin
          beat_we = 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            fill_done = 1'b1;
            state_d   = REREAD;
          end
        end
      end
      REREAD: begin
        stall   = 1'b1;
        busy    = 1'b1;
        state_d = (flush_pend_q || flush) ? FLUSH : LOOKUP;
      end
      FLUSH: begin
        stall       = 1'b1;
        busy        = 1'b1;
        clear_valid = 1'b1;
        state_d     = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
  end

  // Lookup register, fill control, valid bits and pending flush.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      la_q         <= '0;
      lreq_q       <= 1'b0;
      valid_q      <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      if (!stall) begin
        la_q   <= fetch_addr;
        lreq_q <= fetch_req;
      end
      if (start_fill) begin
        mem_req  <= 1'b1;
        mem_addr <= {la_tag, la_idx, OFF_W'(0)};
      end else if (beat_we) begin
        mem_req <= 1'b0;
      end
      if (beat_we) cnt_q <= cnt_q + OFF_W'(1);
      if (clear_valid)    valid_q         <= '0;
      else if (fill_done) valid_q[la_idx] <= 1'b1;
      if (clear_valid) flush_pend_q <= 1'b0;
      else if (flush && (state_q == FILL || state_q == REREAD)) flush_pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized and directed fetch traffic against icache_dm.
// A reference model (resident line per index, memory contents as a function of
// the word address) predicts every response and every line fill; a single
// checker process pops the expectations when the cache answers.
module tb_icache_dm;

  localparam int unsigned LW  = 16;
  localparam int unsigned NL  = 128;
  localparam int unsigned OFW = 4;
  localparam logic [31:0] CB  = 32'h0080_0000;
  localparam logic [31:0] CL  = 32'h0100_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        v;
    logic [31:0] d;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [29:0] addr;
    bit          gap;
  } fill_t;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        flush = 1'b0;
  logic        stall, instr_valid, busy, mem_req;
  logic [31:0] instr_out;
  logic [29:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    tmo_req = 0;
  int    tmo_seen = 0;
  exp_t  exp_q[$];
  fill_t fill_q[$];
  int    resident[int];

  // memory responder state (owned by the checker process)
  bit          active = 0;
  bit          gap_cur = 0;
  int          beat = 0;
  int          gcnt = 0;
  int          beats_sent = 0;
  logic [29:0] base = '0;

  icache_dm #(
    .LINE_WORDS(LW), .NUM_LINES(NL), .CACHE_BASE(CB), .CACHE_LIMIT(CL)
  ) dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .flush(flush), .stall(stall), .instr_valid(instr_valid), .instr_out(instr_out),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  // Backing memory: word 0x20_0010 holds 0x1000 and contents increase by one per word.
  function automatic logic [31:0] mdata(input logic [29:0] wa);
    return {2'b00, wa} - 32'h001F_F010;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Checker: reset values, fetch responses, line-fill requests and beat generation.
  always @(negedge cpu_clk) begin
    exp_t  e;
    fill_t f;
    if (!reset_n) begin
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_out", instr_out, NOP);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      active     = 0;
      beats_sent = 0;
      mem_rvalid = 1'b0;
    end else begin
      if (exp_q.size() != 0 && !stall) begin
        e = exp_q.pop_front();
        chk("instr_valid", 32'(instr_valid), 32'(e.v));
        chk("instr_out", instr_out, e.d);
        if (e.lat != 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end else if (exp_q.size() == 0) begin
        chk("idle_instr_valid", 32'(instr_valid), 32'd0);
      end
      if (!active && mem_req) begin
        if (fill_q.size() == 0) begin
          chk("unexpected_mem_req", 32'(mem_req), 32'd0);
        end else begin
          f = fill_q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(f.addr));
        end
        active  = 1;
        gap_cur = f.gap;
        base    = mem_addr;
        beat    = 0;
        gcnt    = 0;
        beats_sent = 0;
      end
      if (active) begin
        if (!gap_cur || (gcnt % 3) == 2) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mdata(base + 30'(beat));
          beat++;
          if (beat == int'(LW)) active = 0;
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
        end
        gcnt++;
        beats_sent = beat;
      end else begin
        // stray beats outside a fill must be ignored
        mem_rvalid = ($urandom_range(3) == 0);
        mem_rdata  = $urandom;
      end
    end
    if (tmo_req != tmo_seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_bound: got timeout expected progress (cycle %0d)", cyc);
      tmo_seen = tmo_req;
    end
  end

  task automatic wait_no_stall();
    int g = 0;
    while (stall && g < 400) begin
      @(negedge cpu_clk);
      g++;
    end
    if (stall) tmo_req++;
  endtask

  // Issue one fetch; returns one cycle after acceptance with the request still held.
  task automatic fetch(input logic [31:0] a, input bit gap);
    exp_t  e;
    fill_t f;
    bit    cach, miss;
    int    line, idx;
    wait_no_stall();
    fetch_req  = 1'b1;
    fetch_addr = a;
    cach = (a >= CB) && (a < CL);
    line = int'(a >> (2 + OFW));
    idx  = line % int'(NL);
    miss = cach && (!resident.exists(idx) || resident[idx] != line);
    e.v   = cach;
    e.d   = cach ? mdata(a[31:2]) : NOP;
    e.acc = cyc;
    e.lat = !miss ? 1 : (gap ? 0 : int'(LW) + 3);
    f.addr = 30'(line * int'(LW));
    f.gap  = gap;
    if (miss) resident[idx] = line;
    @(posedge cpu_clk);
    exp_q.push_back(e);
    if (miss) fill_q.push_back(f);
    @(negedge cpu_clk);
  endtask

  task automatic idle(input int n);
    wait_no_stall();
    fetch_req = 1'b0;
    repeat (n) @(negedge cpu_clk);
  endtask

  task automatic do_flush();
    int g = 0;
    idle(1);
    #1;
    while (exp_q.size() != 0 && g < 400) begin
      @(negedge cpu_clk);
      #1;
      g++;
    end
    if (exp_q.size() != 0) tmo_req++;
    flush = 1'b1;
    resident.delete();
    @(negedge cpu_clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int g = 0;
    @(negedge cpu_clk);
    #1;
    while (!(active && beats_sent == n) && g < 400) begin
      @(negedge cpu_clk);
      #1;
      g++;
    end
    if (!(active && beats_sent == n)) tmo_req++;
  endtask

  initial begin
    logic [31:0] a;
    int r;
    repeat (3) @(negedge cpu_clk);
    #1 reset_n = 1'b1;
    @(negedge cpu_clk);

    // cold miss, then the next word hits the following cycle
    fetch(32'h0080_0040, 0);
    fetch(32'h0080_0044, 0);
    // sequential hits across the whole line
    for (int k = 0; k < int'(LW); k++) fetch(32'h0080_0040 + 32'(4 * k), 0);
    idle(2);

    // conflict at index 0
    fetch(CB, 0);
    fetch(CB + 32'(NL * LW * 4), 0);
    fetch(CB, 0);
    fetch(CB + 32'h8, 0);
    idle(1);

    // bypass on both sides of the window, plus the last cacheable word
    fetch(32'h0000_0100, 0);
    fetch(32'h0100_0000, 0);
    fetch(32'h007F_FFFC, 0);
    fetch(CL - 32'd4, 0);
    fetch(CL - 32'd8, 0);
    idle(2);

    // flush during a gapped fill: fill completes, flush runs, the held lookup refills
    fetch(32'h0080_0400, 1);
    wait_beats(6);
    flush = 1'b1;
    resident.delete();
    begin
      fill_t f;
      f.addr = 30'(32'h0080_0400 >> 2);
      f.gap  = 0;
      fill_q.push_back(f);
      resident[int'((32'h0080_0400 >> (2 + OFW)) % NL)] = int'(32'h0080_0400 >> (2 + OFW));
    end
    @(negedge cpu_clk);
    #1 flush = 1'b0;
    idle(2);
    fetch(32'h0080_0404, 0);
    idle(1);

    // reset after beat 7 of a fill; the line must refill from scratch
    fetch(32'h0080_0800, 0);
    wait_beats(8);
    @(negedge cpu_clk);
    #1;
    reset_n   = 1'b0;
    fetch_req = 1'b0;
    exp_q.delete();
    fill_q.delete();
    resident.delete();
    repeat (2) @(negedge cpu_clk);
    #1 reset_n = 1'b1;
    @(negedge cpu_clk);
    fetch(32'h0080_0800, 0);
    fetch(32'h0080_083C, 0);
    idle(1);

    // randomized traffic over a few conflicting lines and the window edges
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(9);
      if (r == 0)      a = 32'h0000_0100 + 32'($urandom_range(255) * 4);
      else if (r == 1) a = CL + 32'($urandom_range(255) * 4);
      else if (r == 2) a = CL - 32'd4 - 32'($urandom_range(LW - 1) * 4);
      else a = CB + 32'($urandom_range(2) * NL * LW * 4 + $urandom_range(3) * LW * 4
                        + $urandom_range(LW - 1) * 4);
      a = a + 32'($urandom_range(3));
      fetch(a, $urandom_range(2) == 0);
      r = $urandom_range(19);
      if (r == 0)      do_flush();
      else if (r < 4)  idle($urandom_range(1, 3));
    end

    idle(2);
    begin
      int g = 0;
      while (exp_q.size() != 0 && g < 400) begin
        @(negedge cpu_clk);
        g++;
      end
      if (exp_q.size() != 0) tmo_req++;
    end
    repeat (3) @(negedge cpu_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
